// File: rtl/clkgen_nco_multi.sv
// clkgen_nco_multi: NUM_CH runtime-programmable NCO clocks from refclk with a settle/lock FSM.
// Optional macro CLKGEN_NCO_SYNC_EN adds sync_in to phase-align all enabled channels at once.
module clkgen_nco_multi #(
  parameter int NUM_CH = 4,
  parameter int ACC_W = 32,
  parameter int LOCK_CYC = 16,
  parameter logic [ACC_W-1:0] DEFAULT_FTW = ACC_W'(32'h346D_C5D6),
  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              cfg_wr,
  input  logic [SEL_W-1:0]  cfg_sel,
  input  logic [ACC_W-1:0]  cfg_ftw,
  input  logic [ACC_W-1:0]  cfg_phase,
  output logic              cfg_ack,
  input  logic [NUM_CH-1:0] ch_en,
`ifdef CLKGEN_NCO_SYNC_EN
  input  logic              sync_in,
`endif
  output logic [NUM_CH-1:0] outclk,
  output logic [NUM_CH-1:0] tick,
  output logic              locked
);
  localparam int CNT_W = (LOCK_CYC > 1) ? $clog2(LOCK_CYC) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LOCK_CYC - 1);
  localparam logic [SEL_W:0] NCH = (SEL_W + 1)'(NUM_CH);
  localparam logic [ACC_W-1:0] HALF = {1'b1, {(ACC_W - 1){1'b0}}};
  typedef enum logic {SETTLE, LOCKED} state_t;
  state_t r_state, w_state_nx;
  logic [CNT_W-1:0] r_cnt, w_cnt_nx;
  logic [ACC_W-1:0] r_acc [NUM_CH];
  logic [ACC_W-1:0] r_ftw [NUM_CH];
  logic [ACC_W-1:0] r_phase [NUM_CH];
  logic [NUM_CH-1:0] r_out, r_tick, r_en, w_out_nx, w_hit;
  logic r_ack, w_wr_ok, w_sync, w_restart, w_expire;
  logic [ACC_W-1:0] w_ftw_c;
`ifdef CLKGEN_NCO_SYNC_EN
  assign w_sync = sync_in;
`else
  assign w_sync = 1'b0;
`endif
  // Tuning words at or above refclk/2 would alias, so they saturate to exactly refclk/2.
  assign w_ftw_c = cfg_ftw[ACC_W-1] ? HALF : cfg_ftw;
  assign w_wr_ok = cfg_wr && ({1'b0, cfg_sel} < NCH);
  always_comb begin
    w_out_nx = '0;
    w_hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_out_nx[i] = ch_en[i] & r_acc[i][ACC_W-1];
      w_hit[i] = w_wr_ok && (cfg_sel == SEL_W'(i));
    end
  end
  assign w_restart = (|w_hit) || (ch_en != r_en) || w_sync;
  assign w_expire = (r_state == SETTLE) && (r_cnt == LAST);
  always_comb begin
    w_state_nx = w_restart ? SETTLE : w_expire ? LOCKED : r_state;
    w_cnt_nx = (w_restart || w_expire || r_state == LOCKED) ? '0 : r_cnt + 1'b1;
  end
  always_ff @(posedge refclk or negedge rst)
    if (!rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_acc[i] <= '0;
        r_ftw[i] <= DEFAULT_FTW;
        r_phase[i] <= '0;
      end
      r_out <= '0;
      r_tick <= '0;
      r_en <= '0;
      r_ack <= 1'b0;
      r_state <= SETTLE;
      r_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        // Disabled or synced channels sit at their phase so they restart aligned.
        r_acc[i] <= w_hit[i] ? cfg_phase : (ch_en[i] && !w_sync) ? r_acc[i] + r_ftw[i] : r_phase[i];
        if (w_hit[i]) begin
          r_ftw[i] <= w_ftw_c;
          r_phase[i] <= cfg_phase;
        end
      end
      r_out <= w_out_nx;
      r_tick <= w_out_nx & ~r_out;
      r_en <= ch_en;
      r_ack <= cfg_wr;
      r_state <= w_state_nx;
      r_cnt <= w_cnt_nx;
    end
  assign outclk = r_out;
  assign tick = r_tick;
  assign cfg_ack = r_ack;
  assign locked = (r_state == LOCKED);
endmodule

// File: tb/tb_clkgen_nco_multi.sv
// tb_clkgen_nco_multi: directed and random stimulus against a phase-arithmetic reference model.
module tb_clkgen_nco_multi;
  localparam int N = 6;
`ifdef CLKGEN_NCO_SYNC_EN
  localparam bit SYNC_ON = 1'b1;
`else
  localparam bit SYNC_ON = 1'b0;
`endif
  logic refclk = 1'b0;
  logic rst = 1'b1;
  logic cfg_wr = 1'b0;
  logic [2:0] cfg_sel = '0;
  logic [31:0] cfg_ftw = '0;
  logic [31:0] cfg_phase = '0;
  logic [N-1:0] ch_en = '0;
  logic sync = 1'b0;
  logic cfg_ack, locked;
  logic [N-1:0] outclk, tick;
  int n_chk = 0;
  int n_err = 0;
  logic [31:0] m_ftw [N];
  logic [31:0] m_phase [N];
  logic [31:0] m_base [N];
  int unsigned m_k [N];
  logic [N-1:0] m_en, m_out, m_tick;
  logic m_ack;
  int m_since;

  clkgen_nco_multi #(.NUM_CH(N)) dut (
    .refclk(refclk), .rst(rst), .cfg_wr(cfg_wr), .cfg_sel(cfg_sel),
    .cfg_ftw(cfg_ftw), .cfg_phase(cfg_phase), .cfg_ack(cfg_ack), .ch_en(ch_en),
`ifdef CLKGEN_NCO_SYNC_EN
    .sync_in(sync),
`endif
    .outclk(outclk), .tick(tick), .locked(locked)
  );

  always #10 refclk = ~refclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_ftw[i] = 32'h346D_C5D6;
      m_phase[i] = '0;
      m_base[i] = '0;
      m_k[i] = 0;
    end
    m_en = '0;
    m_out = '0;
    m_tick = '0;
    m_ack = 1'b0;
    m_since = 0;
  endtask

  // Accumulator value = aligned phase + cycles_run * ftw, modulo 2^32.
  task automatic model_edge(input logic wr, input logic [2:0] sel, input logic [31:0] f,
                            input logic [31:0] p, input logic [N-1:0] en, input logic sy);
    logic [N-1:0] nout;
    logic [31:0] a;
    logic restart;
    for (int i = 0; i < N; i++) begin
      a = m_base[i] + m_ftw[i] * m_k[i];
      nout[i] = en[i] & a[31];
    end
    m_tick = nout & ~m_out;
    m_out = nout;
    for (int i = 0; i < N; i++) begin
      if (wr && int'(sel) == i) begin
        m_ftw[i] = (f >= 32'h8000_0000) ? 32'h8000_0000 : f;
        m_phase[i] = p;
        m_base[i] = p;
        m_k[i] = 0;
      end else if (en[i] && !sy) m_k[i]++;
      else begin
        m_base[i] = m_phase[i];
        m_k[i] = 0;
      end
    end
    m_ack = wr;
    restart = (wr && int'(sel) < N) || (en != m_en) || sy;
    m_en = en;
    m_since = restart ? 0 : (m_since < 1000 ? m_since + 1 : m_since);
  endtask

  task automatic cyc(input logic wr, input logic [2:0] sel, input logic [31:0] f,
                     input logic [31:0] p, input logic [N-1:0] en, input logic sy);
    cfg_wr = wr; cfg_sel = sel; cfg_ftw = f; cfg_phase = p; ch_en = en; sync = sy && SYNC_ON;
    model_edge(wr, sel, f, p, en, sy && SYNC_ON);
    @(posedge refclk);
    #1;
    check("outclk", 32'(outclk), 32'(m_out));
    check("tick", 32'(tick), 32'(m_tick));
    check("cfg_ack", 32'(cfg_ack), 32'(m_ack));
    check("locked", 32'(locked), 32'(m_since >= 16));
  endtask

  task automatic run(input int n, input logic [N-1:0] en);
    for (int i = 0; i < n; i++) cyc(1'b0, 3'd0, 32'h0, 32'h0, en, 1'b0);
  endtask

  task automatic do_reset(input logic pend_wr);
    rst = 1'b0;
    cfg_wr = pend_wr; cfg_sel = 3'd1; cfg_ftw = 32'h1234_5678; cfg_phase = 32'h8000_0000;
    #1;
    check("rst_outclk", 32'(outclk), 32'h0);
    check("rst_tick", 32'(tick), 32'h0);
    check("rst_ack", 32'(cfg_ack), 32'h0);
    check("rst_locked", 32'(locked), 32'h0);
    model_reset();
    repeat (2) @(posedge refclk);
    #1;
    cfg_wr = 1'b0;
    ch_en = '0;
    rst = 1'b1;
  endtask

  initial begin
    logic [31:0] f;
    logic [N-1:0] en;
    #3;
    do_reset(1'b0);
    run(40, 6'b000001);
    cyc(1'b1, 3'd1, 32'h4000_0000, 32'h0, 6'b000001, 1'b0);
    run(24, 6'b000011);
    cyc(1'b1, 3'd2, 32'hC000_0000, 32'h0, 6'b000011, 1'b0);
    run(12, 6'b000111);
    cyc(1'b1, 3'd1, 32'h2000_0000, 32'h0, 6'b000111, 1'b0);
    cyc(1'b1, 3'd3, 32'h2000_0000, 32'h8000_0000, 6'b000111, 1'b0);
    run(30, 6'b001111);
    cyc(1'b1, 3'd0, 32'h0, 32'h8000_0000, 6'b001111, 1'b0);
    run(9, 6'b001111);
    cyc(1'b1, 3'd4, 32'h0100_0000, 32'h0, 6'b001111, 1'b0);
    run(20, 6'b011111);
    cyc(1'b1, 3'd7, 32'h4000_0000, 32'h0, 6'b011111, 1'b0);
    cyc(1'b1, 3'd6, 32'h4000_0000, 32'h0, 6'b011111, 1'b0);
    run(4, 6'b011111);
    cyc(1'b1, 3'd5, 32'h1000_0000, 32'h0, 6'b011111, 1'b0);
    cyc(1'b1, 3'd5, 32'h3000_0000, 32'h4000_0000, 6'b111111, 1'b0);
    run(20, 6'b111111);
    cyc(1'b0, 3'd0, 32'h0, 32'h0, 6'b111111, 1'b1);
    run(20, 6'b111111);
    en = 6'b111111;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: f = 32'h0;
        1: f = $urandom;
        2: f = $urandom >> 3;
        default: f = 32'h8000_0000 | $urandom;
      endcase
      if ($urandom_range(0, 31) == 0) en = N'($urandom);
      cyc($urandom_range(0, 7) == 0, 3'($urandom_range(0, 7)), f, $urandom, en,
          $urandom_range(0, 31) == 0);
    end
    cyc(1'b1, 3'd1, 32'h2000_0000, 32'h0, en, 1'b0);
    do_reset(1'b1);
    run(30, 6'b000001);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
